// File: rtl/stream_source_pkg.sv
// stream_source_pkg
// Shared types and constants for the stream_source block:
//   state_t        : top-level FSM encoding (IDLE / STREAM / DONE)
//   DATA_W         : stream word width (64 bits)
//   TIMEOUT_LIMIT  : stall-watchdog terminal count, used only when
//                    STREAM_SOURCE_TIMEOUT_EN is defined
package stream_source_pkg;

    localparam int DATA_W = 64;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/stream_source_fifo.sv
// stream_source_fifo
// Synchronous show-ahead FIFO. The oldest word is always presented on
// o_rd_data; a word written into an empty FIFO is visible the next cycle.
// Ports:
//   i_clk       : clock (rising edge)
//   i_rst       : synchronous active-high reset, flushes the FIFO
//   i_wr_data   : word to write
//   i_wr_en     : write request (ignored while full, even if popping)
//   o_full      : FIFO full
//   i_rd_en     : pop request (ignored while empty)
//   o_rd_data   : oldest stored word
//   o_empty     : FIFO empty
module stream_source_fifo
    import stream_source_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_en,
    output logic              o_full,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("stream_source_fifo: FIFO_DEPTH must be a power of two >= 4");
    end

    // Pointers carry one extra bit so that full and empty differ only in the MSB.
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // Full is judged before any same-cycle pop, so a write into a full FIFO is dropped.
    assign push_s = i_wr_en && !full_s;
    assign pop_s  = i_rd_en && !empty_s;

    assign o_full    = full_s;
    assign o_empty   = empty_s;
    assign o_rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/stream_source.sv
// stream_source
// Buffers host words in a show-ahead FIFO and streams a requested number of
// them to user logic under valid/ack handshaking, then raises a level
// interrupt until acknowledged.
// Optional feature: define STREAM_SOURCE_TIMEOUT_EN to add a 16-bit stall
// watchdog that ends a run after 65535 consecutive stalled cycles.
// Ports:
//   i_clk, i_rst                   : clock, synchronous active-high reset
//   i_wr_data, i_wr_valid,
//   o_wr_ready                     : host write side (ready = not full)
//   i_start, i_word_count          : run start pulse and word count
//   o_busy                         : high in STREAM or DONE
//   o_str_data_valid, o_str_data,
//   i_str_ack                      : stream side
//   o_intr_req, i_intr_ack         : completion interrupt / acknowledge
//   o_sent_count                   : words sent in current/last run
//   o_timeout                      : last run ended by the watchdog
module stream_source
    import stream_source_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic              i_start,
    input  logic [31:0]       i_word_count,
    output logic              o_busy,
    output logic              o_str_data_valid,
    output logic [DATA_W-1:0] o_str_data,
    input  logic              i_str_ack,
    output logic              o_intr_req,
    input  logic              i_intr_ack,
    output logic [31:0]       o_sent_count,
    output logic              o_timeout
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] remaining_r;
    logic [31:0] sent_count_r;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        valid_s;
    logic        xfer_s;
    logic        start_acc_s;
    logic        timeout_hit_s;

    stream_source_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_data (i_wr_data),
        .i_wr_en   (i_wr_valid),
        .o_full    (fifo_full_s),
        .i_rd_en   (xfer_s),
        .o_rd_data (o_str_data),
        .o_empty   (fifo_empty_s)
    );

    assign valid_s     = (state_r == ST_STREAM) && !fifo_empty_s && (remaining_r != 32'd0);
    assign xfer_s      = valid_s && i_str_ack;
    assign start_acc_s = (state_r == ST_IDLE) && i_start;

`ifdef STREAM_SOURCE_TIMEOUT_EN
    logic [15:0] stall_r;
    logic        timeout_r;
    logic        stall_s;

    assign stall_s       = valid_s && !i_str_ack;
    // The cycle that would bring the counter to the limit ends the run.
    assign timeout_hit_s = stall_s && (stall_r == (TIMEOUT_LIMIT - 16'd1));

    // Stall counter and sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_r   <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            if ((state_nxt_s != ST_STREAM) || xfer_s) begin
                stall_r <= 16'd0;
            end else if (stall_s) begin
                stall_r <= stall_r + 16'd1;
            end
            if (start_acc_s) begin
                timeout_r <= 1'b0;
            end else if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_r;
`else
    assign timeout_hit_s = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_word_count == 32'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // Last transfer leaves STREAM on the same edge so valid drops next cycle.
                if (xfer_s && (remaining_r == 32'd1)) begin
                    state_nxt_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                // i_start during the acknowledge cycle is not seen: state is DONE.
                if (i_intr_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and run counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            remaining_r  <= 32'd0;
            sent_count_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (start_acc_s) begin
                remaining_r  <= i_word_count;
                sent_count_r <= 32'd0;
            end else if (xfer_s) begin
                remaining_r  <= remaining_r - 32'd1;
                sent_count_r <= sent_count_r + 32'd1;
            end
        end
    end

    assign o_wr_ready       = !fifo_full_s;
    assign o_busy           = (state_r == ST_STREAM) || (state_r == ST_DONE);
    assign o_str_data_valid = valid_s;
    assign o_intr_req       = (state_r == ST_DONE);
    assign o_sent_count     = sent_count_r;

endmodule
